// File: rtl/im_loader.sv
// Instruction-memory loader: takes 32-bit words from a valid/ready stream and writes them MSB-first
// as four byte writes into the IM array. Optional running XOR checksum under IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned MEM_SIZE = 128,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic [CNT_W-1:0] words_written,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_word, w_word_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             r_last, w_last_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             r_word_ready, r_mem_we, r_busy, r_done;
  logic [31:0]      r_mem_addr, w_mem_addr_nxt;
  logic [7:0]       r_mem_wdata, w_mem_wdata_nxt;

  // Next-state and datapath; bus outputs are derived from the next state so they can be registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_word_nxt      = r_word;
    w_idx_nxt       = r_idx;
    w_last_nxt      = r_last;
    w_err_nxt       = r_err;
    w_cnt_nxt       = r_cnt;
    w_mem_addr_nxt  = 32'h0;
    w_mem_wdata_nxt = 8'h0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ACCEPT;
          w_addr_nxt  = base_addr & ~32'h3;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_ACCEPT: begin
        if (word_valid) begin
          w_word_nxt = word_data;
          w_last_nxt = word_last;
          if (r_addr + 32'd3 < 32'(MEM_SIZE)) begin
            w_state_nxt = S_WRITE;
            w_idx_nxt   = 2'd0;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WRITE: begin
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_addr_nxt  = r_addr + 32'd4;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = r_last ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Byte k of the word is bits [31-8k -: 8], i.e. shift right by 8*(3-k).
    if (w_state_nxt == S_WRITE) begin
      w_mem_addr_nxt  = w_addr_nxt + 32'(w_idx_nxt);
      w_mem_wdata_nxt = 8'(w_word_nxt >> {~w_idx_nxt, 3'b000});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_word       <= 32'h0;
      r_idx        <= 2'd0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_word_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 8'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
      r_last       <= w_last_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word_ready <= (w_state_nxt == S_ACCEPT);
      r_mem_we     <= (w_state_nxt == S_WRITE);
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_busy       <= (w_state_nxt == S_ACCEPT) || (w_state_nxt == S_WRITE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic        w_accept, w_clear;
  logic [31:0] r_csum;

  assign w_accept = (r_state == S_ACCEPT) && word_valid;
  assign w_clear  = (r_state == S_IDLE) && start;

  // Dropped overflow words are still folded in: they were accepted on the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_csum <= 32'h0;
    else if (w_clear)  r_csum <= 32'h0;
    else if (w_accept) r_csum <= r_csum ^ word_data;
  end

  assign checksum = r_csum;
`else
  assign checksum = 32'h0;
`endif

  assign word_ready    = r_word_ready;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_overflow  = r_err;
  assign words_written = r_cnt;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed and random load sessions checked against a byte-level write model.
module tb_im_loader;
  localparam int unsigned MEM_SIZE = 128;
  localparam int unsigned CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = 32'h0;
  logic             word_valid = 1'b0;
  logic [31:0]      word_data = 32'h0;
  logic             word_last = 1'b0;
  logic             word_ready, mem_we, busy, done, err_overflow;
  logic [31:0]      mem_addr, checksum;
  logic [7:0]       mem_wdata;
  logic [CNT_W-1:0] words_written;

  im_loader #(.MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .words_written(words_written), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words[$];
  int          n_total = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_word_ready"}, 32'(word_ready), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err_overflow), 32'h0);
    chk({tag, "_words"}, 32'(words_written), 32'h0);
    chk({tag, "_checksum"}, checksum, 32'h0);
  endtask

  always @(posedge clk) cyc++;

  // Every byte write must match the next expected write, in order.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.a);
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.d));
      end
    end
  end

  // One load session of the words in 'words'; the model stops at the first word that would overflow.
  task automatic session(input logic [31:0] base, input bit gaps, input bit mid_start);
    logic [31:0] a, w, csum;
    int          n_send, exp_cnt, d0, t, last_hs;
    bit          exp_err;
    a = base & ~32'h3; exp_cnt = 0; exp_err = 1'b0; csum = 32'h0; n_send = 0;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      csum ^= w;
      n_send++;
      if (longint'(a) + 3 < longint'(MEM_SIZE)) begin
        for (int k = 0; k < 4; k++) exp_q.push_back('{a: a + 32'(k), d: w[31-8*k -: 8]});
        exp_cnt++;
        a += 32'd4;
      end else begin
        exp_err = 1'b1;
        break;
      end
    end
`ifndef IM_LOADER_CHECKSUM_EN
    csum = 32'h0;
`endif
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; base_addr = base;
    @(posedge clk); #1 start = 1'b0; base_addr = $urandom;
    last_hs = -100;
    for (int i = 0; i < n_send; i++) begin
      word_valid = 1'b1; word_data = words[i]; word_last = (i == words.size() - 1);
      t = 0;
      @(negedge clk);
      while (!word_ready && t < 50) begin @(negedge clk); t++; end
      if (!word_ready) begin
        n_total++;
        $error("FAIL hs_timeout: observed word_ready %b expected 1 within 50 cycles", word_ready);
        break;
      end
      @(posedge clk);
      if (!gaps && i > 0) chk("throughput", 32'(cyc - last_hs), 32'd5);
      last_hs = cyc;
      #1;
      if (!gaps && i + 1 < n_send) begin
        word_data = words[i+1]; word_last = (i + 1 == words.size() - 1);
      end else word_valid = 1'b0;
      if (i < exp_cnt) begin
        @(negedge clk);
        chk("write_mem_we", 32'(mem_we), 32'h1);
        chk("write_busy", 32'(busy), 32'h1);
        chk("write_ready", 32'(word_ready), 32'h0);
        if (mid_start && i == 0) begin
          start = 1'b1; base_addr = 32'h44;
          @(posedge clk); #1 start = 1'b0;
        end
      end
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    word_valid = 1'b0; word_last = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 40) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("words_written", 32'(words_written), 32'(exp_cnt));
    chk("err_overflow", 32'(err_overflow), 32'(exp_err));
    chk("checksum", checksum, csum);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("writes_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] base;
    int          n;
    #12;
    chk_quiet("reset");
    @(negedge clk) rst_n = 1'b1;

    words = '{32'h00A00093};
    session(32'h0, 1'b0, 1'b0);
    words = '{$urandom, $urandom, $urandom};
    session(32'h6, 1'b0, 1'b0);
    words = '{$urandom, $urandom, $urandom};
    session(32'd120, 1'b0, 1'b0);
    words = '{$urandom, $urandom, $urandom};
    session(32'd20, 1'b0, 1'b1);
    words = '{32'h12345678, 32'hFFFF0000};
    session(32'd40, 1'b0, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("checksum_directed", checksum, 32'hEDCB5678);
`else
    chk("checksum_directed", checksum, 32'h0);
`endif
    words = '{$urandom, $urandom};
    session(32'd124, 1'b1, 1'b0);
    words = '{$urandom};
    session(32'd128, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      words.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      base = $urandom_range(0, 140);
      session(base, r[0], r[1]);
    end

    // Reset asserted while byte 1 of a word is being written.
    exp_q.delete();
    exp_q.push_back('{a: 32'h40, d: 8'hDE});
    @(posedge clk); #1 start = 1'b1; base_addr = 32'h40;
    @(posedge clk); #1 start = 1'b0;
    word_valid = 1'b1; word_data = 32'hDEADBEEF; word_last = 1'b1;
    n = 0;
    @(negedge clk);
    while (!word_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 word_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("post_reset");
    chk("rst_writes_left", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
